// File: rtl/lcd_read_fsm_if.sv
// Bus bundle between the top-level sequencer and the LCD read engine.
// The slave modport is the engine. The master modport is the sequencer that requests reads.
interface lcd_read_fsm_if;
    logic       ENABLE;
    logic       rs_sel;
    logic [3:0] SF_D_in;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       bus_own;
    logic [7:0] read_data;
    logic       busy_flag;
    logic       FSM_done;

    modport slave (
        input  ENABLE, rs_sel, SF_D_in,
        output LCD_E, LCD_RS, LCD_RW, bus_own, read_data, busy_flag, FSM_done
    );

    modport master (
        output ENABLE, rs_sel, SF_D_in,
        input  LCD_E, LCD_RS, LCD_RW, bus_own, read_data, busy_flag, FSM_done
    );
endinterface

// File: rtl/lcd_read_fsm.sv
// Performs one 4-bit HD44780 read (two E pulses, upper nibble first) and returns the byte.
// Every output is a register, so no input reaches an output combinationally.
module lcd_read_fsm #(
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 12,
    parameter int GAP_CYC    = 50,
    parameter int HOLD_CYC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    lcd_read_fsm_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE, SETUP, E_UPPER, GAP, E_LOWER, HOLD, DONE
    } state_t;

    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] EHIGH_LD = 16'(E_HIGH_CYC - 1);
    localparam logic [15:0] GAP_LD   = 16'(GAP_CYC - 1);
    localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        rsLatch_q;
    logic [3:0]  upper_q;
    logic [3:0]  lower_q;
    logic        lcdE_q;
    logic        lcdRs_q;
    logic        lcdRw_q;
    logic        busOwn_q;
    logic [7:0]  readData_q;
    logic        busyFlag_q;
    logic        done_q;

    // The counter is loaded with (length-1) on entry; a state ends on the edge where it reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rsLatch_q  <= 1'b0;
            upper_q    <= '0;
            lower_q    <= '0;
            lcdE_q     <= 1'b0;
            lcdRs_q    <= 1'b0;
            lcdRw_q    <= 1'b0;
            busOwn_q   <= 1'b0;
            readData_q <= '0;
            busyFlag_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ENABLE) begin
                        rsLatch_q <= bus.rs_sel;
                        lcdRs_q   <= bus.rs_sel;
                        lcdRw_q   <= 1'b1;
                        busOwn_q  <= 1'b1;
                        cnt_q     <= SETUP_LD;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        lcdE_q  <= 1'b1;
                        cnt_q   <= EHIGH_LD;
                        state_q <= E_UPPER;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                E_UPPER: begin
                    if (cnt_q == '0) begin
                        upper_q <= bus.SF_D_in;
                        lcdE_q  <= 1'b0;
                        cnt_q   <= GAP_LD;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        lcdE_q  <= 1'b1;
                        cnt_q   <= EHIGH_LD;
                        state_q <= E_LOWER;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                E_LOWER: begin
                    if (cnt_q == '0) begin
                        lower_q <= bus.SF_D_in;
                        lcdE_q  <= 1'b0;
                        cnt_q   <= HOLD_LD;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        readData_q <= {upper_q, lower_q};
                        busyFlag_q <= ~rsLatch_q & upper_q[3];
                        done_q     <= 1'b1;
                        lcdRs_q    <= 1'b0;
                        lcdRw_q    <= 1'b0;
                        busOwn_q   <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DONE: begin
                    // Holding here until ENABLE drops prevents a level-held request from retriggering.
                    if (!bus.ENABLE) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.LCD_E     = lcdE_q;
    assign bus.LCD_RS    = lcdRs_q;
    assign bus.LCD_RW    = lcdRw_q;
    assign bus.bus_own   = busOwn_q;
    assign bus.read_data = readData_q;
    assign bus.busy_flag = busyFlag_q;
    assign bus.FSM_done  = done_q;

endmodule

// File: doc/lcd_read_fsm.md
Name: lcd_read_fsm

Overview:
- Read-side companion to the LCD instruction writer, for the HD44780-compatible character LCD on its 4-bit bus (LCD_E, LCD_RS, LCD_RW, SF_D11..SF_D8).
- On request, performs one read transaction (RW=1): two E pulses, upper nibble first, then lower nibble.
- Returns the 8-bit value read.
- Used by the top-level sequencer to poll the busy flag/address counter (RS=0) or read DDRAM/CGRAM data (RS=1) instead of waiting fixed delays.

Parameters:
- SETUP_CYC, 2, cycles RS/RW held stable with E low before first E rise (40 ns at 50 MHz).
- E_HIGH_CYC, 12, cycles per E-high pulse (240 ns at 50 MHz); must be >=1.
- GAP_CYC, 50, E-low cycles between upper and lower nibble pulses (1 us); must be >=1.
- HOLD_CYC, 1, E-low cycles after the second pulse before completion; must be >=1.

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- ENABLE  input  1  level request; a transaction starts when sampled high in IDLE.
- rs_sel  input  1  register select for the read; 0 = busy flag/address, 1 = data RAM; latched at start.
- SF_D_in  input  4  LCD data pins D7..D4 as seen from the pad input buffers.
- LCD_E  output  1  LCD enable strobe.
- LCD_RS  output  1  LCD register select.
- LCD_RW  output  1  LCD read/write; 1 = read.
- bus_own  output  1  high during a transaction; the top level gives LCD_* to this block and tristates FPGA SF_D drivers.
- read_data  output  8  assembled byte {upper, lower}.
- busy_flag  output  1  read_data[7] if the latched rs_sel was 0, else 0.
- FSM_done  output  1  transaction complete.

Behaviour:
- Clocking and reset:
  - All outputs are registered; there is no combinational path from inputs to outputs.
  - reset (sync, active-high) forces IDLE and clears all counters.
  - Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, bus_own=0, read_data=8'h00, busy_flag=0, FSM_done=0.
- States: IDLE, SETUP, E_UPPER, GAP, E_LOWER, HOLD, DONE. A single down-counter is loaded on each state entry.
- IDLE:
  - All outputs keep their reset levels except read_data/busy_flag, which hold the last result.
  - If ENABLE=1: latch rs_sel and go to SETUP.
- SETUP (SETUP_CYC cycles): bus_own=1, LCD_RW=1, LCD_RS=latched rs_sel, LCD_E=0.
- E_UPPER (E_HIGH_CYC cycles):
  - LCD_E=1.
  - SF_D_in is captured into upper nibble on the clock edge that ends the state, while E is still high.
- GAP (GAP_CYC cycles): LCD_E=0.
- E_LOWER (E_HIGH_CYC cycles): LCD_E=1; lower nibble is captured on the final edge, the same way as the upper nibble.
- HOLD (HOLD_CYC cycles): LCD_E=0, RS/RW unchanged.
- DONE:
  - read_data and busy_flag update on entry.
  - FSM_done=1, LCD_RW=0, LCD_RS=0, bus_own=0.
  - Remains in DONE while ENABLE=1; goes to IDLE on the first cycle ENABLE=0. FSM_done is therefore high for at least 1 cycle.
  - No retrigger occurs without ENABLE first dropping.
- Latency:
  - FSM_done first rises SETUP_CYC+2*E_HIGH_CYC+GAP_CYC+HOLD_CYC clock edges after the edge that samples ENABLE=1 in IDLE.
  - With defaults this is 77 edges.
  - First LCD_E rise is SETUP_CYC edges after that edge.
- RS/RW stability: LCD_RS and LCD_RW never change while LCD_E=1. They change only in IDLE→SETUP and HOLD→DONE.
- ENABLE or rs_sel changes mid-transaction: ignored. The transaction completes. If ENABLE is already 0 at DONE entry, FSM_done is a single-cycle pulse.
- Reset mid-transaction: abort on the next edge to reset values; read_data is cleared; no partial result is published.
- SF_D_in is not sampled in any state other than the two capture edges.

Test Plan:
- Data read:
  - Stimulus: rs_sel=1, ENABLE held high; LCD model drives SF_D_in=4'hA during the 1st E pulse and 4'h5 during the 2nd.
  - Response: read_data=8'hA5, busy_flag=0, FSM_done high at edge 77, LCD_RS=1 and LCD_RW=1 throughout both pulses.
- Busy poll:
  - Stimulus: rs_sel=0; model drives 4'h8 then 4'h3.
  - Response: read_data=8'h83, busy_flag=1, LCD_RS=0 while E pulses.
  - Repeat with 4'h0/4'h3: busy_flag=0.
- Timing:
  - Stimulus: count cycles between strobe edges.
  - Response: E-high widths exactly 12 cycles, gap exactly 50, first E rise exactly 2 cycles after start, bus_own high from SETUP through HOLD only.
- Capture point:
  - Stimulus: model drives 4'hF until the last E_UPPER cycle, then 4'h6; lower nibble 4'h9.
  - Response: read_data=8'h69; a pulse-start glitch is not captured.
- Handshake:
  - Stimulus: ENABLE high 200 cycles.
  - Response: FSM_done stays high from edge 77 until ENABLE drops, then IDLE next cycle.
  - Stimulus: a second ENABLE with data 4'h1/4'h2.
  - Response: read_data=8'h12.
  - Stimulus: ENABLE dropped at cycle 10.
  - Response: transaction completes and FSM_done is a 1-cycle pulse.
- Reset mid-op:
  - Stimulus: assert reset for 1 cycle during GAP.
  - Response: next cycle LCD_E=0, LCD_RW=0, bus_own=0, read_data=8'h00, FSM_done=0.
  - Stimulus: a new ENABLE.
  - Response: a full normal transaction.
